// File: rtl/aes256_key_expander.sv
// -----------------------------------------------------------------------------
// aes256_key_expander
//
// Expands a 256-bit AES cipher key into the 15 AES-256 round keys, one round
// key per clock, and keeps them in a small round-key memory. The encipher
// stage reads any stored round key combinationally by round index.
//
// The SubWord S-box is not instantiated here. The word to be substituted is
// presented on sboxw and the parent returns the substituted word on new_sboxw
// in the same cycle, so several blocks can share one set of S-boxes.
//
// Handshake: init is a single-cycle request. It is accepted only on a rising
// edge where ready=1. ready stays low while the schedule is being written and
// rises once all 15 entries hold the new schedule. init seen while ready=0 is
// dropped. The round_key port is only meaningful while ready=1.
//
// Ports
//   clk        in   1    system clock, rising edge
//   reset_n    in   1    synchronous active-low reset
//   key        in   256  cipher key, key[255:224] is word w0; sampled on accept
//   init       in   1    start expansion (single-cycle pulse)
//   round      in   4    round-key index to read
//   round_key  out  128  mem[round] for round 0..14, zero for round 15
//   sboxw      out  32   SubWord operand (last word of the previous round key)
//   new_sboxw  in   32   SubWord result for sboxw, same cycle
//   ready      out  1    idle with a complete schedule in memory
// -----------------------------------------------------------------------------
module aes256_key_expander #(
    parameter int NUM_ROUNDS = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic         init,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    output logic         ready
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_GENERATE = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [255:0]   r_key;
    logic [3:0]     r_counter;
    logic [7:0]     r_rcon;
    logic [127:0]   r_prev_key0;
    logic [127:0]   r_prev_key1;
    logic [127:0]   r_mem [NUM_ROUNDS];
    logic           r_ready;

    logic           w_start;
    logic           w_gen;
    logic           w_last;
    logic           w_rcon_step;
    logic [31:0]    w_tmp;
    logic [31:0]    w_k0;
    logic [31:0]    w_k1;
    logic [31:0]    w_k2;
    logic [31:0]    w_k3;
    logic [127:0]   w_write_data;
    logic [7:0]     w_rcon_next;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (init) w_next_state = S_GENERATE;
            S_GENERATE: if (r_counter == LAST_IDX) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_start     = (r_state == S_IDLE) && init;
        w_gen       = (r_state == S_GENERATE);
        w_last      = w_gen && (r_counter == LAST_IDX);
        // Even rounds from 2 upward use the RotWord+Rcon form and advance rcon.
        w_rcon_step = (r_counter[3:1] != 3'd0) && !r_counter[0];
    end

    // ---------------- round-key datapath ----------------
    always_comb begin
        // RotWord after SubWord equals SubWord after RotWord (bytewise map).
        if (w_rcon_step) begin
            w_tmp = {new_sboxw[23:0], new_sboxw[31:24]} ^ {r_rcon, 24'h0};
        end else begin
            w_tmp = new_sboxw;
        end
        w_k0 = r_prev_key0[127:96] ^ w_tmp;
        w_k1 = r_prev_key0[95:64]  ^ w_k0;
        w_k2 = r_prev_key0[63:32]  ^ w_k1;
        w_k3 = r_prev_key0[31:0]   ^ w_k2;

        case (r_counter)
            4'd0:    w_write_data = r_key[255:128];
            4'd1:    w_write_data = r_key[127:0];
            default: w_write_data = {w_k0, w_k1, w_k2, w_k3};
        endcase

        // xtime: GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
        w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_key       <= '0;
            r_counter   <= '0;
            r_rcon      <= 8'h01;
            r_prev_key0 <= '0;
            r_prev_key1 <= '0;
            r_ready     <= 1'b1;
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_start) begin
            r_key     <= key;
            r_counter <= '0;
            r_rcon    <= 8'h01;
            r_ready   <= 1'b0;
        end else if (w_gen) begin
            r_mem[r_counter] <= w_write_data;
            if (r_counter == 4'd0) begin
                r_prev_key0 <= w_write_data;
            end else if (r_counter == 4'd1) begin
                r_prev_key1 <= w_write_data;
            end else begin
                r_prev_key0 <= r_prev_key1;
                r_prev_key1 <= w_write_data;
            end
            if (w_rcon_step) begin
                r_rcon <= w_rcon_next;
            end
            if (w_last) begin
                r_counter <= '0;
                r_ready   <= 1'b1;
            end else begin
                r_counter <= r_counter + 4'd1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign sboxw     = r_prev_key1[31:0];
    assign ready     = r_ready;
    assign round_key = (round <= LAST_IDX) ? r_mem[round] : '0;

endmodule
